// File: rtl/legv8_imm_pkg.sv
// Shared LEGv8 immediate-decode definitions: format codes, opcode match
// values and immediate field positions within the 32-bit instruction word.
package legv8_imm_pkg;

  typedef enum logic [2:0] {
    FMT_B    = 3'd0,
    FMT_CB   = 3'd1,
    FMT_D    = 3'd2,
    FMT_I    = 3'd3,
    FMT_IW   = 3'd4,
    FMT_NONE = 3'd7
  } imm_fmt_e;

  // Opcode match values, compared against the top bits of the instruction.
  localparam logic [5:0]  OP_B     = 6'b000101;        // [31:26]
  localparam logic [5:0]  OP_BL    = 6'b100101;        // [31:26]
  localparam logic [7:0]  OP_CBZ   = 8'b10110100;      // [31:24]
  localparam logic [7:0]  OP_CBNZ  = 8'b10110101;      // [31:24]
  localparam logic [7:0]  OP_BCOND = 8'b01010100;      // [31:24]
  localparam logic [10:0] OP_LDUR  = 11'b11111000010;  // [31:21]
  localparam logic [10:0] OP_STUR  = 11'b11111000000;  // [31:21]
  localparam logic [9:0]  OP_ADDI  = 10'b1001000100;   // [31:22]
  localparam logic [9:0]  OP_ADDIS = 10'b1011000100;   // [31:22]
  localparam logic [9:0]  OP_SUBI  = 10'b1101000100;   // [31:22]
  localparam logic [9:0]  OP_SUBIS = 10'b1111000100;   // [31:22]
  localparam logic [8:0]  OP_MOVZ  = 9'b110100101;     // [31:23]
  localparam logic [8:0]  OP_MOVK  = 9'b111100101;     // [31:23]

  // Immediate field positions (lsb, width).
  localparam int B_IMM_LSB  = 0;
  localparam int B_IMM_W    = 26;
  localparam int CB_IMM_LSB = 5;
  localparam int CB_IMM_W   = 19;
  localparam int D_IMM_LSB  = 12;
  localparam int D_IMM_W    = 9;
  localparam int I_IMM_LSB  = 10;
  localparam int I_IMM_W    = 12;
  localparam int IW_IMM_LSB = 5;
  localparam int IW_IMM_W   = 16;
  localparam int IW_HW_LSB  = 21;
  localparam int IW_HW_W    = 2;

endpackage

// File: rtl/imm_decode.sv
// Combinational LEGv8 immediate decoder: instruction word -> extended
// immediate, format code and illegal flag. Formats are matched in priority
// order B, CB, D, I, IW; anything else is illegal with imm=0, fmt=NONE.
// Optional macro IMM_BRANCH_SHIFT_EN: B/CB immediates become byte offsets
// (word offset shifted left by 2, sign kept).
module imm_decode #(
  parameter int DATA_W = 64
) (
  input  logic [31:0]       instr,
  output logic [DATA_W-1:0] imm,
  output logic [2:0]        fmt,
  output logic              illegal
);
  import legv8_imm_pkg::*;

  logic [63:0] iw_wide;

  // MOVZ/MOVK: 16-bit field placed at 16*hw; bits above DATA_W are dropped below.
  assign iw_wide = {48'd0, instr[IW_IMM_LSB +: IW_IMM_W]} << {instr[IW_HW_LSB +: IW_HW_W], 4'b0000};

  // Priority format match and immediate extraction.
  always_comb begin
    imm     = '0;
    fmt     = FMT_NONE;
    illegal = 1'b1;
    if (instr[31:26] == OP_B || instr[31:26] == OP_BL) begin
`ifdef IMM_BRANCH_SHIFT_EN
      imm = {{(DATA_W-B_IMM_W-2){instr[B_IMM_LSB+B_IMM_W-1]}}, instr[B_IMM_LSB +: B_IMM_W], 2'b00};
`else
      imm = {{(DATA_W-B_IMM_W){instr[B_IMM_LSB+B_IMM_W-1]}}, instr[B_IMM_LSB +: B_IMM_W]};
`endif
      fmt     = FMT_B;
      illegal = 1'b0;
    end else if (instr[31:24] == OP_CBZ || instr[31:24] == OP_CBNZ ||
                 instr[31:24] == OP_BCOND) begin
`ifdef IMM_BRANCH_SHIFT_EN
      imm = {{(DATA_W-CB_IMM_W-2){instr[CB_IMM_LSB+CB_IMM_W-1]}}, instr[CB_IMM_LSB +: CB_IMM_W], 2'b00};
`else
      imm = {{(DATA_W-CB_IMM_W){instr[CB_IMM_LSB+CB_IMM_W-1]}}, instr[CB_IMM_LSB +: CB_IMM_W]};
`endif
      fmt     = FMT_CB;
      illegal = 1'b0;
    end else if (instr[31:21] == OP_LDUR || instr[31:21] == OP_STUR) begin
      imm     = {{(DATA_W-D_IMM_W){instr[D_IMM_LSB+D_IMM_W-1]}}, instr[D_IMM_LSB +: D_IMM_W]};
      fmt     = FMT_D;
      illegal = 1'b0;
    end else if (instr[31:22] == OP_ADDI || instr[31:22] == OP_ADDIS ||
                 instr[31:22] == OP_SUBI || instr[31:22] == OP_SUBIS) begin
      imm     = {{(DATA_W-I_IMM_W){1'b0}}, instr[I_IMM_LSB +: I_IMM_W]};
      fmt     = FMT_I;
      illegal = 1'b0;
    end else if (instr[31:23] == OP_MOVZ || instr[31:23] == OP_MOVK) begin
      imm     = iw_wide[DATA_W-1:0];
      fmt     = FMT_IW;
      illegal = 1'b0;
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decodes at the input, then carries
// {imm, fmt, illegal} through STAGES valid/ready registers. Supports flush
// and keeps a saturating count of accepted illegal instructions.
// Optional macro IMM_BRANCH_SHIFT_EN (handled in imm_decode): B/CB
// immediates are emitted as byte offsets.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// A producer holds valid and its payload stable until the transfer; ready
// may be asserted without valid. Stage k accepts whenever it is empty or
// every stage from k to the output is full and the consumer is ready, so
// bubbles compress and nothing is lost or duplicated.
module imm_gen_pipe #(
  parameter int DATA_W = 64,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_imm,
  output logic [2:0]        out_fmt,
  output logic              out_illegal,
  output logic [CNT_W-1:0]  ill_cnt
);
  import legv8_imm_pkg::*;

  logic [DATA_W-1:0] dec_imm;
  logic [2:0]        dec_fmt;
  logic              dec_ill;

  logic [STAGES-1:0] vld;
  logic [DATA_W-1:0] imm_q [STAGES];
  logic [2:0]        fmt_q [STAGES];
  logic [STAGES-1:0] ill_q;
  logic [STAGES-1:0] rdy;
  logic              full_tail;
  logic              accept;

  imm_decode #(.DATA_W(DATA_W)) u_dec (
    .instr   (in_instr),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_ill)
  );

  // Stage k may load unless it and every stage after it are full and stalled.
  always_comb begin
    rdy       = '0;
    full_tail = 1'b1;
    for (int k = 0; k < STAGES; k++) begin
      full_tail = 1'b1;
      for (int j = k; j < STAGES; j++) full_tail = full_tail & vld[j];
      rdy[k] = !full_tail || out_ready;
    end
  end

  assign in_ready    = rdy[0];
  assign accept      = in_valid && in_ready;
  assign out_valid   = vld[STAGES-1];
  assign out_imm     = imm_q[STAGES-1];
  assign out_fmt     = fmt_q[STAGES-1];
  assign out_illegal = ill_q[STAGES-1];

  // Pipeline registers: flush drops everything, otherwise each ready stage shifts in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld   <= '0;
      ill_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        imm_q[k] <= '0;
        fmt_q[k] <= FMT_NONE;
      end
    end else if (flush) begin
      vld <= '0;
    end else begin
      if (rdy[0]) begin
        vld[0] <= in_valid;
        if (in_valid) begin
          imm_q[0] <= dec_imm;
          fmt_q[0] <= dec_fmt;
          ill_q[0] <= dec_ill;
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (rdy[k]) begin
          vld[k] <= vld[k-1];
          if (vld[k-1]) begin
            imm_q[k] <= imm_q[k-1];
            fmt_q[k] <= fmt_q[k-1];
            ill_q[k] <= ill_q[k-1];
          end
        end
      end
    end
  end

  // Count accepted illegal instructions that survive the cycle; stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ill_cnt <= '0;
    end else if (accept && dec_ill && !flush && ill_cnt != {CNT_W{1'b1}}) begin
      ill_cnt <= ill_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: directed format vectors, a stalled back-to-back
// stream, flush of an illegal entry, randomized traffic with flush and a
// mid-stream reset, and illegal-counter saturation.
module tb_imm_gen_pipe;
  localparam int DATA_W  = 64;
  localparam int STAGES  = 2;
  localparam int CNT_W   = 16;
  localparam int W       = DATA_W + 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_imm;
  logic [2:0]        out_fmt;
  logic              out_illegal;
  logic [CNT_W-1:0]  ill_cnt;

  imm_gen_pipe #(.DATA_W(DATA_W), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_imm     (out_imm),
    .out_fmt     (out_fmt),
    .out_illegal (out_illegal),
    .ill_cnt     (ill_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];   // {illegal, fmt, imm}
  int           acc_q[$];   // cycle of acceptance for each queued entry
  int           ill_model = 0;
  int           last_pop  = -100;
  int           checks    = 0;
  int           failures  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference decode straight from the format rules, using integer arithmetic.
  function automatic logic [W-1:0] ref_imm(input logic [31:0] ins);
    longint      v;
    logic [63:0] u;
    logic [2:0]  f;
    logic        il;
    v = 0; f = 3'd7; il = 1'b1;
    if (ins[31:26] == 6'b000101 || ins[31:26] == 6'b100101) begin
      v = longint'(ins[25:0]);
      if (v >= 64'sd33554432) v = v - 64'sd67108864;
`ifdef IMM_BRANCH_SHIFT_EN
      v = v * 4;
`endif
      f = 3'd0; il = 1'b0;
    end else if (ins[31:24] == 8'hB4 || ins[31:24] == 8'hB5 || ins[31:24] == 8'h54) begin
      v = longint'(ins[23:5]);
      if (v >= 64'sd262144) v = v - 64'sd524288;
`ifdef IMM_BRANCH_SHIFT_EN
      v = v * 4;
`endif
      f = 3'd1; il = 1'b0;
    end else if (ins[31:21] == 11'b11111000010 || ins[31:21] == 11'b11111000000) begin
      v = longint'(ins[20:12]);
      if (v >= 64'sd256) v = v - 64'sd512;
      f = 3'd2; il = 1'b0;
    end else if (ins[31:22] == 10'b1001000100 || ins[31:22] == 10'b1011000100 ||
                 ins[31:22] == 10'b1101000100 || ins[31:22] == 10'b1111000100) begin
      v = longint'(ins[21:10]);
      f = 3'd3; il = 1'b0;
    end else if (ins[31:23] == 9'b110100101 || ins[31:23] == 9'b111100101) begin
      u = 64'(ins[20:5]) * (64'd1 << (16 * int'(ins[22:21])));
      v = longint'(u);
      f = 3'd4; il = 1'b0;
    end
    u = 64'(v);
    return {il, f, u[DATA_W-1:0]};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 6))
      0: r[31:26] = ($urandom_range(0, 1) != 0) ? 6'b000101 : 6'b100101;
      1: case ($urandom_range(0, 2))
           0: r[31:24] = 8'hB4;
           1: r[31:24] = 8'hB5;
           default: r[31:24] = 8'h54;
         endcase
      2: r[31:21] = ($urandom_range(0, 1) != 0) ? 11'b11111000010 : 11'b11111000000;
      3: case ($urandom_range(0, 3))
           0: r[31:22] = 10'b1001000100;
           1: r[31:22] = 10'b1011000100;
           2: r[31:22] = 10'b1101000100;
           default: r[31:22] = 10'b1111000100;
         endcase
      4: r[31:23] = ($urandom_range(0, 1) != 0) ? 9'b110100101 : 9'b111100101;
      default: ;
    endcase
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  // Drive one cycle of inputs at the falling edge; record accepted entries.
  task automatic step(input logic iv, input logic [31:0] ins, input logic fl,
                      input logic ordy, output logic acc);
    logic [W-1:0] e;
    @(negedge clk);
    in_valid  = iv;
    in_instr  = ins;
    flush     = fl;
    out_ready = ordy;
    #2;
    acc = iv && in_ready;
    if (fl) begin
      exp_q.delete();
      acc_q.delete();
    end else if (acc) begin
      e = ref_imm(ins);
      exp_q.push_back(e);
      acc_q.push_back(cyc);
      if (e[W-1] && ill_model < CNT_MAX) ill_model++;
    end
  endtask

  task automatic send(input logic [31:0] ins, input logic ordy);
    logic a;
    int   n;
    a = 1'b0; n = 0;
    while (!a && n < 50) begin
      step(1'b1, ins, 1'b0, ordy, a);
      n++;
    end
    if (!a) begin
      checks++; failures++;
      $display("FAIL send_timeout actual=not_accepted expected=accepted instr=%0h", ins);
    end
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, 1'b1, a);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    flush    = 1'b0;
    exp_q.delete();
    acc_q.delete();
    ill_model = 0;
    last_pop  = -100;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- monitor ----------------
  logic [W-1:0] prev_out;
  logic         prev_stall = 1'b0;

  initial begin
    logic [W-1:0] e;
    logic         exp_ov;
    int           due;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_imm", 128'(out_imm), 128'(0));
        chk("rst_out_fmt", 128'(out_fmt), 128'(7));
        chk("rst_out_illegal", 128'(out_illegal), 128'(0));
        chk("rst_ill_cnt", 128'(ill_cnt), 128'(0));
        prev_stall = 1'b0;
        continue;
      end
      chk("in_ready", 128'(in_ready), 128'((exp_q.size() < STAGES) || out_ready));
      chk("ill_cnt", 128'(ill_cnt), 128'(ill_model));
      exp_ov = 1'b0;
      if (exp_q.size() > 0) begin
        due = acc_q[0] + STAGES;
        if (last_pop + 1 > due) due = last_pop + 1;
        exp_ov = (cyc >= due);
      end
      chk("out_valid", 128'(out_valid), 128'(exp_ov));
      if (prev_stall) chk("stall_stable", 128'({out_illegal, out_fmt, out_imm}), 128'(prev_out));
      if (out_valid && out_ready && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        void'(acc_q.pop_front());
        chk("out_data", 128'({out_illegal, out_fmt, out_imm}), 128'(e));
        last_pop = cyc;
      end
      prev_stall = out_valid && !out_ready && !flush;
      prev_out   = {out_illegal, out_fmt, out_imm};
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] stream [6];
  logic        pend;
  logic [31:0] pins;
  logic        a;
  logic        fl;
  int          idx;
  int          n;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = 32'd0; flush = 1'b0; out_ready = 1'b1;
    do_reset();
    idle(2);

    // Directed format vectors.
    send(32'h17FFFFFF, 1'b1);
    idle(3);
    send(32'hB4000040, 1'b1);
    send(32'hF85FF000, 1'b1);
    send(32'h913FFC00, 1'b1);
    send(32'hD2C24680, 1'b1);
    send(32'h54FFFFE1, 1'b1);  // B.cond, negative
    send(32'h97FFFFF0, 1'b1);  // BL, negative
    send(32'hF2E00020, 1'b1);  // MOVK hw=3
    idle(4);

    // Back-to-back stream of 6 with the consumer stalled on cycles 3..5.
    stream[0] = 32'h17FFFFFF; stream[1] = 32'hB5FFFFE0; stream[2] = 32'hF8000000;
    stream[3] = 32'hF1000400; stream[4] = 32'hD2A00020; stream[5] = 32'hFFFFFFFF;
    idx = 0;
    for (int t = 0; t < 40 && idx < 6; t++) begin
      step(1'b1, stream[idx], 1'b0, !(t >= 3 && t <= 5), a);
      if (a) idx++;
    end
    chk("stream_accepted", 128'(idx), 128'(6));
    idle(6);

    // Illegal entry flushed before it reaches the output; it is still counted.
    do_reset();
    idle(1);
    send(32'h00000000, 1'b1);
    step(1'b0, 32'd0, 1'b1, 1'b1, a);
    idle(4);
    chk("flush_ill_cnt", 128'(ill_cnt), 128'(1));

    // Randomized traffic with flush and a mid-stream reset.
    pend = 1'b0; pins = 32'd0;
    for (int t = 0; t < 3000; t++) begin
      if (t == 1500) begin
        do_reset();
        pend = 1'b0;
      end
      if (!pend) begin
        pend = ($urandom_range(0, 3) != 0);
        pins = rand_instr();
      end
      fl = ($urandom_range(0, 31) == 0);
      step(pend, pins, fl, $urandom_range(0, 3) != 0, a);
      if (a || fl) pend = 1'b0;
    end
    idle(6);

    // Counter saturation: 2^CNT_W + 5 illegal accepts.
    do_reset();
    n = 0;
    for (int t = 0; t < CNT_MAX + 200 && n < CNT_MAX + 6; t++) begin
      step(1'b1, 32'h00000000, 1'b0, 1'b1, a);
      if (a) n++;
    end
    chk("sat_accepts", 128'(n), 128'(CNT_MAX + 6));
    idle(3);
    chk("sat_ill_cnt", 128'(ill_cnt), 128'(CNT_MAX));

    // Drain.
    n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      step(1'b0, 32'd0, 1'b0, 1'b1, a);
      n++;
    end
    chk("drain_empty", 128'(exp_q.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
